demux_sel_sequencer: RTL and testbench
======================================

# demux_sel_sequencer

- Command-driven sequencer that sits directly upstream of the 1x8 demux.
- Generates the demux data bit `I` and the 3-bit select `s` for a programmed number of cycles, either on one fixed channel or sweeping across channels.
- Accepts commands over a valid/ready handshake and reports progress with `busy` and a one-cycle `done` pulse.

## Interface
Parameters:
- LEN_W, default 8: width of the command length field; maximum run is 2^LEN_W−1 cycles.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: sequencer can take a command.
- cmd_ch, input, 3: start channel, 0..7.
- cmd_data, input, 1: bit value to drive on `I`.
- cmd_len, input, LEN_W: number of drive cycles.
- cmd_mode, input, 1: 0 = HOLD (fixed channel), 1 = SWEEP (channel increments each cycle).
- I, output, 1: data bit to demux input.
- s, output, 3: select to demux.
- out_en, output, 1: high in every drive cycle.
- busy, output, 1: a command is executing.
- done, output, 1: one-cycle pulse marking the end of a command.

## Operation
- States:
  - IDLE: no command executing.
  - RUN: drive cycles in progress; internal `remaining` counter of LEN_W bits.
  - ZDONE: zero-length completion.
- Transitions:
  - IDLE → RUN on accept (`cmd_valid && cmd_ready`) with `cmd_len != 0`. The command fields are latched; `remaining` loads `cmd_len`.
  - IDLE → ZDONE on accept with `cmd_len == 0`.
  - ZDONE → IDLE after one cycle. In ZDONE: `done=1`, `out_en=0`, `busy=1`.
  - RUN: each cycle drives `I = latched data`, `s = current channel`, `out_en=1`, and decrements `remaining`.
    - HOLD mode: channel is constant.
    - SWEEP mode: channel increments by 1 per cycle and wraps modulo 8 (7 → 0).
  - RUN: when `remaining == 1`, that cycle is the last drive cycle and `done=1` is asserted coincident with it. The next state is IDLE, or RUN with the next command (see Configuration).
- Outputs when not in RUN: `I=0`, `s=0`, `out_en=0`.
- `busy` is high in RUN and ZDONE.
- `cmd_ch`, `cmd_data`, `cmd_mode` and `cmd_len` are sampled only on accept. Later changes have no effect on an executing command.
- `cmd_valid` while `cmd_ready=0` is held by the source. It is not dropped and not accepted.

## Timing
- All outputs are registered.
- Reset (rst_n low at a rising edge) clears state to IDLE and forces `I=0`, `s=0`, `out_en=0`, `busy=0`, `done=0`. It also clears `remaining` and any pending command.
- `cmd_ready` is 1 in the first cycle after reset release.
- Reset during RUN aborts immediately: no `done` is issued, and the aborted command is lost.
- Latency: a command accepted at edge N gives its first drive cycle in cycle N+1. It occupies exactly `cmd_len` consecutive drive cycles.
- A HOLD command covering up to 2^LEN_W−1 cycles has no gaps.

## Configuration
- Macro `DSEQ_QUEUE_EN` controls back-to-back command handling.
- Defined: adds a one-entry pending command buffer.
  - `cmd_ready` = IDLE, or RUN with the buffer empty.
  - A command accepted during RUN (including on the last drive cycle) starts in the cycle immediately after the current last drive cycle, with zero idle cycles between runs.
  - A pending zero-length command enters ZDONE directly.
- Not defined: no buffer.
  - `cmd_ready` = (state == IDLE).
  - At least one idle cycle separates consecutive runs.

## Test plan
1. Reset, then HOLD `ch=5`, `data=1`, `len=3` → `out_en=1`, `s=5`, `I=1` for exactly 3 cycles starting the cycle after accept. `done` is high on the 3rd cycle; then `s=0`, `I=0`, `busy=0`.
2. SWEEP `ch=6`, `data=1`, `len=4` → `s` sequence 6, 7, 0, 1. Downstream demux `y` = 0x40, 0x80, 0x01, 0x02.
3. `len=0` command → no `out_en` cycle. `done` and `busy` are high for one cycle after accept, and `cmd_ready` returns the following cycle.
4. Back-to-back: HOLD `ch=2` `len=2`, then HOLD `ch=3` `len=2` presented immediately with `cmd_valid` held.
   - With `DSEQ_QUEUE_EN`: `s` = 2, 2, 3, 3 contiguous.
   - Without it: one `out_en=0` cycle between the runs.
5. Assert `rst_n=0` in the 2nd cycle of a `len=5` run → next cycle all outputs are 0, no `done` is issued, and the run does not resume after release.
6. `cmd_valid` high while `busy` with the buffer full (queue build) or while RUN (no-queue build) → `cmd_ready=0`, and the command is accepted only once `cmd_ready` rises. `cmd_data=0` runs drive `I=0` with `out_en=1`.

Source files
------------

// File: rtl/demux_sel_sequencer_if.sv
// Command and drive bundle between a command source and demux_sel_sequencer.
// The master side issues commands and observes the demux drive outputs.
interface demux_sel_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_ch;
    logic             cmd_data;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_mode;
    logic             I;
    logic [2:0]       s;
    logic             out_en;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_ch, cmd_data, cmd_len, cmd_mode,
        input  cmd_ready, I, s, out_en, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_data, cmd_len, cmd_mode,
        output cmd_ready, I, s, out_en, busy, done
    );
endinterface

// File: rtl/demux_sel_sequencer.sv
// Drives data bit I and select s of a 1x8 demux for cmd_len cycles (HOLD or SWEEP).
// Define DSEQ_QUEUE_EN to add a one-entry pending buffer for gapless back-to-back runs.
module demux_sel_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_sel_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ZDONE
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [2:0]       ch_q, ch_d;
    logic             data_q, data_d;
    logic             mode_q, mode_d;

    logic             i_q, i_d;
    logic [2:0]       s_q, s_d;
    logic             out_en_q, out_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic             accept;
    logic             ld_valid;
    logic [2:0]       ld_ch;
    logic             ld_data;
    logic [LEN_W-1:0] ld_len;
    logic             ld_mode;

`ifdef DSEQ_QUEUE_EN
    logic             pend_valid_q, pend_valid_d;
    logic [2:0]       pend_ch_q, pend_ch_d;
    logic             pend_data_q, pend_data_d;
    logic [LEN_W-1:0] pend_len_q, pend_len_d;
    logic             pend_mode_q, pend_mode_d;
`endif

    assign accept = bus.cmd_valid && ready_q;

    // Next command to start: the pending entry has priority over the live bus.
    always_comb begin
        ld_valid = accept;
        ld_ch    = bus.cmd_ch;
        ld_data  = bus.cmd_data;
        ld_len   = bus.cmd_len;
        ld_mode  = bus.cmd_mode;
`ifdef DSEQ_QUEUE_EN
        if (pend_valid_q) begin
            ld_valid = 1'b1;
            ld_ch    = pend_ch_q;
            ld_data  = pend_data_q;
            ld_len   = pend_len_q;
            ld_mode  = pend_mode_q;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ch_d        = ch_q;
        data_d      = data_q;
        mode_d      = mode_q;
`ifdef DSEQ_QUEUE_EN
        pend_valid_d = pend_valid_q;
        pend_ch_d    = pend_ch_q;
        pend_data_d  = pend_data_q;
        pend_len_d   = pend_len_q;
        pend_mode_d  = pend_mode_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    ch_d        = ld_ch;
                    data_d      = ld_data;
                    mode_d      = ld_mode;
                    remaining_d = ld_len;
                    state_d     = (ld_len != '0) ? RUN : ZDONE;
                end
            end
            RUN: begin
                if (remaining_q == LEN_W'(1)) begin
                    state_d     = IDLE;
                    remaining_d = '0;
`ifdef DSEQ_QUEUE_EN
                    if (ld_valid) begin
                        ch_d         = ld_ch;
                        data_d       = ld_data;
                        mode_d       = ld_mode;
                        remaining_d  = ld_len;
                        state_d      = (ld_len != '0) ? RUN : ZDONE;
                        pend_valid_d = 1'b0;
                    end
`endif
                end else begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (mode_q) begin
                        ch_d = ch_q + 3'd1;
                    end
`ifdef DSEQ_QUEUE_EN
                    if (accept) begin
                        pend_valid_d = 1'b1;
                        pend_ch_d    = bus.cmd_ch;
                        pend_data_d  = bus.cmd_data;
                        pend_len_d   = bus.cmd_len;
                        pend_mode_d  = bus.cmd_mode;
                    end
`endif
                end
            end
            ZDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        out_en_d = (state_d == RUN);
        i_d      = out_en_d && data_d;
        s_d      = out_en_d ? ch_d : 3'd0;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == ZDONE) || ((state_d == RUN) && (remaining_d == LEN_W'(1)));
`ifdef DSEQ_QUEUE_EN
        ready_d  = (state_d == IDLE) || ((state_d == RUN) && !pend_valid_d);
`else
        ready_d  = (state_d == IDLE);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            ch_q        <= 3'd0;
            data_q      <= 1'b0;
            mode_q      <= 1'b0;
            i_q         <= 1'b0;
            s_q         <= 3'd0;
            out_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            ch_q        <= ch_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            i_q         <= i_d;
            s_q         <= s_d;
            out_en_q    <= out_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

`ifdef DSEQ_QUEUE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_ch_q    <= 3'd0;
            pend_data_q  <= 1'b0;
            pend_len_q   <= '0;
            pend_mode_q  <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_ch_q    <= pend_ch_d;
            pend_data_q  <= pend_data_d;
            pend_len_q   <= pend_len_d;
            pend_mode_q  <= pend_mode_d;
        end
    end
`endif

    assign bus.I         = i_q;
    assign bus.s         = s_q;
    assign bus.out_en    = out_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cmd_ready = ready_q;
endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Directed self-checking bench for demux_sel_sequencer (both DSEQ_QUEUE_EN builds).
module tb_demux_sel_sequencer;
    localparam int LEN_W = 8;

    logic clk;
    logic rst_n;
    int   total_count;
    int   pass_count;
    logic [7:0] y_obs;

    demux_sel_sequencer_if #(.LEN_W(LEN_W)) bus ();

    demux_sel_sequencer #(.LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic check_drive(input string tag, input logic oe, input logic [2:0] sel,
                               input logic data, input logic dn, input logic bz);
        check_output({tag, ".out_en"}, 32'(bus.out_en), 32'(oe));
        check_output({tag, ".s"},      32'(bus.s),      32'(sel));
        check_output({tag, ".I"},      32'(bus.I),      32'(data));
        check_output({tag, ".done"},   32'(bus.done),   32'(dn));
        check_output({tag, ".busy"},   32'(bus.busy),   32'(bz));
    endtask

    task automatic apply_stimulus(input logic valid, input logic [2:0] ch, input logic data,
                                  input logic [LEN_W-1:0] len, input logic mode);
        bus.cmd_valid = valid;
        bus.cmd_ch    = ch;
        bus.cmd_data  = data;
        bus.cmd_len   = len;
        bus.cmd_mode  = mode;
    endtask

    initial begin
        logic [2:0] exp_s [4];
        logic [7:0] exp_y [4];
        exp_s = '{3'd6, 3'd7, 3'd0, 3'd1};
        exp_y = '{8'h40, 8'h80, 8'h01, 8'h02};
        total_count = 0;
        pass_count  = 0;

        // Reset
        rst_n = 1'b0;
        apply_stimulus(1'b0, 3'd0, 1'b0, 8'd0, 1'b0);
        tick();
        tick();
        check_drive("rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_output("rst.ready", 32'(bus.cmd_ready), 32'd1);

        // Test 1: HOLD ch5 data1 len3
        apply_stimulus(1'b1, 3'd5, 1'b1, 8'd3, 1'b0);
        tick();
        apply_stimulus(1'b0, 3'd0, 1'b0, 8'd0, 1'b0);
        check_drive("t1.c1", 1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
        tick();
        check_drive("t1.c2", 1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
        tick();
        check_drive("t1.c3", 1'b1, 3'd5, 1'b1, 1'b1, 1'b1);
        tick();
        check_drive("t1.end", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_output("t1.ready", 32'(bus.cmd_ready), 32'd1);

        // Test 2: SWEEP ch6 data1 len4 with wrap 7 -> 0
        apply_stimulus(1'b1, 3'd6, 1'b1, 8'd4, 1'b1);
        tick();
        apply_stimulus(1'b0, 3'd0, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            y_obs = (bus.out_en && bus.I) ? (8'd1 << bus.s) : 8'd0;
            check_output($sformatf("t2.s%0d", k), 32'(bus.s), 32'(exp_s[k]));
            check_output($sformatf("t2.y%0d", k), 32'(y_obs), 32'(exp_y[k]));
            check_output($sformatf("t2.done%0d", k), 32'(bus.done), (k == 3) ? 32'd1 : 32'd0);
            tick();
        end
        check_drive("t2.end", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // Test 3: zero-length command
        apply_stimulus(1'b1, 3'd4, 1'b1, 8'd0, 1'b0);
        tick();
        apply_stimulus(1'b0, 3'd0, 1'b0, 8'd0, 1'b0);
        check_drive("t3.z", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        check_output("t3.zready", 32'(bus.cmd_ready), 32'd0);
        tick();
        check_drive("t3.end", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_output("t3.ready", 32'(bus.cmd_ready), 32'd1);

        // Test 4: back-to-back HOLD ch2 len2 then HOLD ch3 len2 with valid held
        apply_stimulus(1'b1, 3'd2, 1'b1, 8'd2, 1'b0);
        tick();
        apply_stimulus(1'b1, 3'd3, 1'b1, 8'd2, 1'b0);
`ifdef DSEQ_QUEUE_EN
        check_drive("t4.a1", 1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
        check_output("t4.a1ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        apply_stimulus(1'b0, 3'd0, 1'b0, 8'd0, 1'b0);
        check_drive("t4.a2", 1'b1, 3'd2, 1'b1, 1'b1, 1'b1);
        check_output("t4.a2ready", 32'(bus.cmd_ready), 32'd0);
        tick();
`else
        check_drive("t4.a1", 1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
        check_output("t4.a1ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        check_drive("t4.a2", 1'b1, 3'd2, 1'b1, 1'b1, 1'b1);
        check_output("t4.a2ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        check_drive("t4.gap", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_output("t4.gapready", 32'(bus.cmd_ready), 32'd1);
        tick();
        apply_stimulus(1'b0, 3'd0, 1'b0, 8'd0, 1'b0);
`endif
        check_drive("t4.b1", 1'b1, 3'd3, 1'b1, 1'b0, 1'b1);
        tick();
        check_drive("t4.b2", 1'b1, 3'd3, 1'b1, 1'b1, 1'b1);
        tick();
        check_drive("t4.end", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // Test 5: reset in 2nd cycle of a len5 run
        apply_stimulus(1'b1, 3'd1, 1'b1, 8'd5, 1'b0);
        tick();
        apply_stimulus(1'b0, 3'd0, 1'b0, 8'd0, 1'b0);
        check_drive("t5.c1", 1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
        tick();
        check_drive("t5.c2", 1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        tick();
        check_drive("t5.rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_output($sformatf("t5.post_oe%0d", k), 32'(bus.out_en), 32'd0);
            check_output($sformatf("t5.post_done%0d", k), 32'(bus.done), 32'd0);
        end

        // Test 6: held valid while not ready; data0 run drives I=0
        apply_stimulus(1'b1, 3'd4, 1'b0, 8'd2, 1'b0);
        tick();
        apply_stimulus(1'b1, 3'd7, 1'b1, 8'd1, 1'b0);
`ifdef DSEQ_QUEUE_EN
        check_drive("t6.c1", 1'b1, 3'd4, 1'b0, 1'b0, 1'b1);
        check_output("t6.c1ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        apply_stimulus(1'b1, 3'd0, 1'b1, 8'd1, 1'b0);
        check_drive("t6.c2", 1'b1, 3'd4, 1'b0, 1'b1, 1'b1);
        check_output("t6.c2ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        check_drive("t6.d1", 1'b1, 3'd7, 1'b1, 1'b1, 1'b1);
        check_output("t6.d1ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        apply_stimulus(1'b0, 3'd0, 1'b0, 8'd0, 1'b0);
        check_drive("t6.e1", 1'b1, 3'd0, 1'b1, 1'b1, 1'b1);
        tick();
`else
        check_drive("t6.c1", 1'b1, 3'd4, 1'b0, 1'b0, 1'b1);
        check_output("t6.c1ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        check_drive("t6.c2", 1'b1, 3'd4, 1'b0, 1'b1, 1'b1);
        check_output("t6.c2ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        check_drive("t6.gap", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_output("t6.gapready", 32'(bus.cmd_ready), 32'd1);
        tick();
        apply_stimulus(1'b0, 3'd0, 1'b0, 8'd0, 1'b0);
        check_drive("t6.d1", 1'b1, 3'd7, 1'b1, 1'b1, 1'b1);
        tick();
`endif
        check_drive("t6.end", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_output("t6.ready", 32'(bus.cmd_ready), 32'd1);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule
